// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset pulse, lock wait and lock-stability qualification
// ahead of releasing the system reset; re-arms the system reset on lock loss.
// Latency: lock status seen 2 clk after pll_unlocked_in; every output is registered (+1 clk).
// Backpressure: none; free-running sequencer on the PLL reference clock.
//
// Ports:
//   clk              reference clock (same source as PLL clk_in)
//   reset            asynchronous active-high reset
//   pll_unlocked_in  PLL reset_out (1 = not locked), asynchronous to clk
//   soft_reset_req   synchronous request to restart the whole sequence
//   pll_reset_req    drives PLL reset_in
//   sys_reset_out    active-high system reset, low only in RUN
//   state_o          0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//   retry_cnt        saturating count of lock-timeout retries
//   lock_lost        one-cycle pulse when lock drops while in RUN
//
// Optional feature: define PLL_RST_TIMEOUT_EN to retry the PLL reset when lock
// does not arrive within TIMEOUT_CYCLES cycles of WAIT_LOCK.

module pll_reset_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 256,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned CNT_W          = 17,
  parameter int unsigned RETRY_W        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_unlocked_in,
  input  logic               soft_reset_req,
  output logic               pll_reset_req,
  output logic               sys_reset_out,
  output logic [1:0]         state_o,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost
);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Terminal counts of the shared counter for each timed state.
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = '1;

  // ---------------------------------------------------------------------------
  // Lock synchronizer. Both flops reset to "unlocked" so nothing downstream
  // can see a false lock while the chain is still filling after reset.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       locked_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pll_unlocked_in};
    end
  end

  assign locked_s = ~sync_q[1];

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t             state_q,         state_d;
  logic [CNT_W-1:0]   cnt_q,           cnt_d;
  logic [RETRY_W-1:0] retry_q,         retry_d;
  logic               pll_reset_req_q, pll_reset_req_d;
  logic               sys_reset_q,     sys_reset_d;
  logic               lock_lost_q,     lock_lost_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_PLL_RST;
      cnt_q           <= '0;
      retry_q         <= '0;
      pll_reset_req_q <= 1'b1;
      sys_reset_q     <= 1'b1;
      lock_lost_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      retry_q         <= retry_d;
      pll_reset_req_q <= pll_reset_req_d;
      sys_reset_q     <= sys_reset_d;
      lock_lost_q     <= lock_lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    unique case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        // Lock arriving on the timeout cycle still wins: no needless retry.
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
`ifdef PLL_RST_TIMEOUT_EN
          if (cnt_q == TIMEOUT_LAST) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            if (retry_q != RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          // Waiting is unbounded here; park the counter at the timeout value
          // rather than letting it wrap, so it still reads "waited long".
          if (cnt_q != TIMEOUT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end

      ST_STABLE: begin
        // Any dropout restarts qualification from WAIT_LOCK with a fresh count.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        // The PLL is left running; only the system side is put back in reset.
        if (!locked_s) begin
          state_d     = ST_WAIT_LOCK;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Soft reset overrides every transition, but a coincident lock loss in RUN
    // is still reported (lock_lost_d is deliberately left untouched).
    if (soft_reset_req) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
    end

`ifndef PLL_RST_TIMEOUT_EN
    retry_d = '0;
`endif
  end

  // Outputs are registered from the next state so they switch with state_o.
  assign pll_reset_req_d = (state_d == ST_PLL_RST);
  assign sys_reset_d     = (state_d != ST_RUN);

  assign pll_reset_req = pll_reset_req_q;
  assign sys_reset_out = sys_reset_q;
  assign state_o       = state_q;
  assign retry_cnt     = retry_q;
  assign lock_lost     = lock_lost_q;

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset sequencer that sits on the other side of the PLL wrapper. It drives the PLL's `reset_in` and consumes the PLL's `reset_out` (the inverse of lock). It holds the PLL in reset for a fixed time, then waits for lock and requires lock to stay stable before releasing the system reset. It re-asserts system reset on lock loss and, optionally, retries the PLL on lock timeout. It runs on the free-running reference clock that also feeds the PLL `clk_in`.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_reset_req` is held high per PLL reset pulse (>=2).
- `STABLE_CYCLES`, 256: consecutive locked cycles required before system reset release (>=1).
- `TIMEOUT_CYCLES`, 65536: maximum cycles spent in WAIT_LOCK before a PLL retry (used only with macro).
- `CNT_W`, 17: shared counter width; must hold max(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES)-1.
- `RETRY_W`, 4: retry counter width.

Ports:
- `clk`, in, 1: reference clock (same source as PLL clk_in).
- `reset`, in, 1: asynchronous, active-high.
- `pll_unlocked_in`, in, 1: PLL `reset_out` (1 = not locked); asynchronous to `clk`.
- `soft_reset_req`, in, 1: synchronous request; restarts the full sequence.
- `pll_reset_req`, out, 1: to PLL `reset_in`.
- `sys_reset_out`, out, 1: active-high system reset.
- `state_o`, out, 2: current state (0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN).
- `retry_cnt`, out, RETRY_W: number of timeout retries, saturating.
- `lock_lost`, out, 1: one-cycle pulse on lock loss while in RUN.

## Operation
- `pll_unlocked_in` passes through a 2-flop synchronizer whose flops reset to 1. `locked_s` = ~sync output.
- All outputs are registered. Reset values: `pll_reset_req`=1, `sys_reset_out`=1, `state_o`=0, `retry_cnt`=0, `lock_lost`=0. `cnt` resets to 0.
- PLL_RST: `pll_reset_req`=1. At cnt==RST_CYCLES-1, go to WAIT_LOCK with cnt=0; otherwise cnt++.
- WAIT_LOCK: `pll_reset_req`=0. If `locked_s`, go to STABLE with cnt=0; otherwise cnt++. Timeout behaviour is described under Configuration.
- STABLE: if !`locked_s`, go to WAIT_LOCK with cnt=0. Else at cnt==STABLE_CYCLES-1, go to RUN; otherwise cnt++.
- RUN: `sys_reset_out`=0. If !`locked_s`, go to WAIT_LOCK with cnt=0 and pulse `lock_lost`. The PLL itself is not reset on lock loss.
- `sys_reset_out` is 1 in every state except RUN. It is registered from the next state, so it changes on the same edge as `state_o`.
- `soft_reset_req`=1 in any state goes to PLL_RST with cnt=0. It has priority over every other transition. If it coincides with lock loss in RUN, `lock_lost` still pulses.
- `retry_cnt` clears only on `reset` and saturates at all-ones.
- When `reset` is asserted mid-sequence, all state and outputs return to their reset values immediately (asynchronously).

## Timing
- Lock status latency: 2 clk edges from a `pll_unlocked_in` change to `locked_s`.
- With lock already stable, `sys_reset_out` falls on edge RST_CYCLES+1+STABLE_CYCLES after reset release. With defaults this is edge 273.
- Lock loss in RUN: `sys_reset_out` rises and `lock_lost` pulses 3 edges after `pll_unlocked_in` rises (2 sync + 1 register).
- A lock glitch shorter than STABLE_CYCLES during STABLE restarts the stability count from 0 on re-lock.

## Configuration
- `PLL_RST_TIMEOUT_EN` defined:
  - In WAIT_LOCK, at cnt==TIMEOUT_CYCLES-1 with !`locked_s`, go to PLL_RST with cnt=0 and `retry_cnt`++ (saturating).
  - `locked_s` on the same edge wins over the timeout.
- Undefined:
  - WAIT_LOCK waits indefinitely.
  - `retry_cnt` is held at 0.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Reset release with `pll_unlocked_in`=0, defaults -> `pll_reset_req` high for edges 1-16 and low from edge 16; `sys_reset_out` falls at edge 273; `state_o`=3.
- In RUN, raise `pll_unlocked_in` -> on edge 3 `sys_reset_out`=1, `lock_lost` high for one cycle, `state_o`=1, `pll_reset_req` stays 0; drop `pll_unlocked_in` -> RUN again after 2+1+256 edges.
- During STABLE at cnt=200, a 5-cycle unlock pulse -> returns to WAIT_LOCK, then a full 256-cycle STABLE; `sys_reset_out` never drops during the glitch.
- Macro on, TIMEOUT_CYCLES=100, `pll_unlocked_in` held 1 -> `pll_reset_req` pulses 16 cycles every 116 cycles; `retry_cnt` counts 1,2,… and saturates at 15.
- `soft_reset_req` pulse in RUN -> next edge `state_o`=0, `pll_reset_req`=1, `sys_reset_out`=1; full sequence repeats (273 edges to RUN).
- Async `reset` asserted mid-STABLE -> all outputs immediately at reset values without a clock edge.
